// File: rtl/iob_pipe_split_pkg.sv
`default_nettype none
// ============================================================================
// Package     : iob_pipe_split_pkg
// Description : Shared IOB definitions for the pipelined address splitter:
//               default request/response field widths, the byte-strobe
//               read-detection rule and the default error read data.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iob_pipe_split_pkg;

    // Default IOB field widths
    localparam int c_iob_addr_w = 32;
    localparam int c_iob_data_w = 32;

    // Data returned for reads that hit no slave
    localparam logic [31:0] c_iob_err_data = 32'hDEADBEEF;

    // Widest strobe field the read-detection helper accepts (DATA_W up to 512)
    localparam int c_iob_max_strb_w = 64;

    // One strobe bit per data byte
    function automatic int iob_strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // An IOB request with no byte strobes set is a read
    function automatic logic iob_is_read(input logic [c_iob_max_strb_w-1:0] wstrb);
        return (wstrb == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_pipe_split_ctr.sv
`default_nettype none
// ============================================================================
// Module      : iob_pipe_split_ctr
// Description : Outstanding-read tracker for iob_pipe_split. Keeps the count
//               of reads awaiting a response and the index of the target that
//               owns them, and decides when a new request has to stall.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               cke            - clock enable, state holds when low
//               req_valid      - master request valid
//               req_idx        - target index of the request (N_SLAVES=error)
//               rd_acc         - a read is accepted this cycle
//               rsp_take       - a response is delivered to the master
//               stall          - request must be held off this cycle
//               cnt, cur_sel   - outstanding count / owning target index
// Revision    : 1.0 - initial release
// ============================================================================
module iob_pipe_split_ctr #(
    parameter int MAX_OUTST = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             rd_acc,
    input  logic             rsp_take,
    output logic             stall,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] cur_sel
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_cur_sel;

    logic w_busy;
    logic w_full;
    logic w_other;

    assign w_busy  = (r_cnt != '0);
    // A response retiring this cycle frees a slot, so a full pipe can still
    // take a read to the same target in that very cycle.
    assign w_full  = (r_cnt == CNT_W'(MAX_OUTST)) && !rsp_take;
    // Responses are matched by ordering only, so a different target must
    // wait until every read owned by the current one has returned.
    assign w_other = w_busy && (req_idx != r_cur_sel);
    assign stall   = req_valid && (w_full || w_other);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cur_sel <= '0;
        end else if (cke) begin
            if (rd_acc && !rsp_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!rd_acc && rsp_take) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (rd_acc) begin
                r_cur_sel <= req_idx;
            end
        end
    end

    assign cnt     = r_cnt;
    assign cur_sel = r_cur_sel;

endmodule
`default_nettype wire

// File: rtl/iob_pipe_split.sv
`default_nettype none
// ============================================================================
// Module      : iob_pipe_split
// Description : Pipelined IOB 1-to-N address splitter. Selects a slave from
//               an address field, routes requests combinationally, allows up
//               to MAX_OUTST reads in flight to one slave, and answers
//               unmapped reads from an internal error responder.
// Ports       : clk_i, arst_i, cke_i         - clock, async reset, enable
//               m_*                          - master-side IOB port
//               s_avalid_o / s_ready_i / s_rvalid_i - per-slave handshake
//               s_addr_o / s_wdata_o / s_wstrb_o    - broadcast request
//               s_rdata_i                    - slave k at [k*DATA_W +: DATA_W]
//               err_o, err_clr_i             - sticky unmapped-access flag
// Revision    : 1.0 - initial release
// ============================================================================
module iob_pipe_split
    import iob_pipe_split_pkg::*;
#(
    parameter int                ADDR_W    = c_iob_addr_w,
    parameter int                DATA_W    = c_iob_data_w,
    parameter int                N_SLAVES  = 2,
    parameter int                SEL_MSB   = ADDR_W - 2,
    parameter int                MAX_OUTST = 4,
    parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(c_iob_err_data)
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           cke_i,
    input  logic                           m_avalid_i,
    input  logic [ADDR_W-1:0]              m_addr_i,
    input  logic [DATA_W-1:0]              m_wdata_i,
    input  logic [iob_strb_w(DATA_W)-1:0]  m_wstrb_i,
    output logic                           m_ready_o,
    output logic [DATA_W-1:0]              m_rdata_o,
    output logic                           m_rvalid_o,
    output logic [N_SLAVES-1:0]            s_avalid_o,
    output logic [ADDR_W-1:0]              s_addr_o,
    output logic [DATA_W-1:0]              s_wdata_o,
    output logic [iob_strb_w(DATA_W)-1:0]  s_wstrb_o,
    input  logic [N_SLAVES-1:0]            s_ready_i,
    input  logic [N_SLAVES*DATA_W-1:0]     s_rdata_i,
    input  logic [N_SLAVES-1:0]            s_rvalid_i,
    output logic                           err_o,
    input  logic                           err_clr_i
);

    localparam int c_sel_w = $clog2(N_SLAVES);
    // One extra index value is needed for the internal error responder
    localparam int c_idx_w = $clog2(N_SLAVES + 1);
    localparam int c_cnt_w = $clog2(MAX_OUTST + 1);

    logic [c_sel_w-1:0]          w_sel;
    logic [c_idx_w-1:0]          w_sel_ext;
    logic                        w_unmapped;
    logic [c_idx_w-1:0]          w_req_idx;
    logic [c_iob_max_strb_w-1:0] w_strb_ext;
    logic                        w_is_read;
    logic                        w_stall;
    logic                        w_accept;
    logic                        w_rd_acc;
    logic [c_cnt_w-1:0]          w_cnt;
    logic [c_idx_w-1:0]          w_cur_sel;
    logic                        w_cur_err;
    logic                        w_slv_rvalid;
    logic [DATA_W-1:0]           w_slv_rdata;
    logic                        w_rsp;

    logic                        r_err_pend;
    logic                        r_err;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_sel      = m_addr_i[SEL_MSB -: c_sel_w];
    assign w_sel_ext  = c_idx_w'(w_sel);
    assign w_unmapped = (w_sel_ext >= c_idx_w'(N_SLAVES));
    assign w_req_idx  = w_unmapped ? c_idx_w'(N_SLAVES) : w_sel_ext;
    assign w_strb_ext = c_iob_max_strb_w'(m_wstrb_i);
    assign w_is_read  = iob_is_read(w_strb_ext);

    iob_pipe_split_ctr #(
        .MAX_OUTST (MAX_OUTST),
        .IDX_W     (c_idx_w),
        .CNT_W     (c_cnt_w)
    ) u_ctr (
        .clk       (clk_i),
        .rst       (arst_i),
        .cke       (cke_i),
        .req_valid (m_avalid_i),
        .req_idx   (w_req_idx),
        .rd_acc    (w_rd_acc),
        .rsp_take  (w_rsp),
        .stall     (w_stall),
        .cnt       (w_cnt),
        .cur_sel   (w_cur_sel)
    );

    // ------------------------------------------------------------------
    // Request routing: zero-latency, unmapped requests are absorbed here
    // ------------------------------------------------------------------
    always_comb begin
        s_avalid_o = '0;
        m_ready_o  = 1'b0;
        if (!w_stall) begin
            if (w_unmapped) begin
                m_ready_o = 1'b1;
            end else begin
                s_avalid_o[w_sel] = m_avalid_i;
                m_ready_o         = s_ready_i[w_sel];
            end
        end
    end

    assign w_accept = m_avalid_i && m_ready_o;
    assign w_rd_acc = w_accept && w_is_read;

    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_wstrb_o = m_wstrb_i;

    // ------------------------------------------------------------------
    // Response selection from the owning slave
    // ------------------------------------------------------------------
    always_comb begin
        w_slv_rvalid = 1'b0;
        w_slv_rdata  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (w_cur_sel == c_idx_w'(k)) begin
                w_slv_rvalid = s_rvalid_i[k];
                w_slv_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_cur_err = (w_cur_sel == c_idx_w'(N_SLAVES));
    // Responses with nothing outstanding, or from a non-owner, are dropped
    assign w_rsp     = (w_cnt != '0) && (w_cur_err ? r_err_pend : w_slv_rvalid);

    assign m_rvalid_o = w_rsp;
    assign m_rdata_o  = !w_rsp   ? '0 :
                        w_cur_err ? ERR_DATA : w_slv_rdata;

    // ------------------------------------------------------------------
    // Error responder and sticky error flag
    // ------------------------------------------------------------------
    // err_pend is a one-cycle pulse: the error response always lands in the
    // cycle right after the unmapped read is accepted.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
        end else if (cke_i) begin
            r_err_pend <= w_rd_acc && w_unmapped;
            if (err_clr_i) begin
                r_err <= 1'b0;
            end else if (w_accept && w_unmapped) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iob_pipe_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_pipe_split
// Description : Self-checking bench for iob_pipe_split with three slaves
//               (select field addr[31:30], selector 3 unmapped) and up to
//               three outstanding reads. Directed scenarios plus a random
//               run against a queue-based reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_pipe_split;

    localparam int NS   = 3;
    localparam int MAXO = 3;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        arst, cke, m_avalid, m_ready, m_rvalid, err, err_clr;
    logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic [3:0]  m_wstrb, s_wstrb;
    logic [2:0]  s_avalid, s_ready, s_rvalid;
    logic [95:0] s_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of the targets of reads still awaiting a response
    int          mq[$];
    bit          err_due;
    bit          exp_err;
    logic        exp_ready, exp_rvalid;
    logic [2:0]  exp_sav;
    logic [31:0] exp_rdata;
    bit          exp_accept, exp_read;
    int          exp_tgt;

    always #5 clk = ~clk;

    iob_pipe_split #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .N_SLAVES  (NS),
        .SEL_MSB   (31),
        .MAX_OUTST (MAXO),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .cke_i      (cke),
        .m_avalid_i (m_avalid),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_wstrb_i  (m_wstrb),
        .m_ready_o  (m_ready),
        .m_rdata_o  (m_rdata),
        .m_rvalid_o (m_rvalid),
        .s_avalid_o (s_avalid),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_ready_i  (s_ready),
        .s_rdata_i  (s_rdata),
        .s_rvalid_i (s_rvalid),
        .err_o      (err),
        .err_clr_i  (err_clr)
    );

    task automatic model_reset();
        mq.delete();
        err_due = 1'b0;
        exp_err = 1'b0;
    endtask

    // Expected outputs for the current inputs and model state
    task automatic model_eval();
        int sel, n, owner;
        bit rsp, stall;
        sel     = int'(m_addr[31:30]);
        exp_tgt = (sel >= NS) ? NS : sel;
        exp_read = (m_wstrb == 4'h0);
        n       = mq.size();
        owner   = (n > 0) ? mq[0] : -1;
        rsp     = 1'b0;
        if (n > 0) rsp = (owner == NS) ? err_due : s_rvalid[owner];
        exp_rvalid = rsp;
        exp_rdata  = '0;
        if (rsp) exp_rdata = (owner == NS) ? ERRD : s_rdata[owner*32 +: 32];
        stall   = m_avalid && (((n == MAXO) && !rsp) || ((n > 0) && (exp_tgt != owner)));
        exp_sav = '0;
        if (!stall && m_avalid && exp_tgt < NS) exp_sav[exp_tgt] = 1'b1;
        exp_ready  = !stall && ((exp_tgt == NS) ? 1'b1 : s_ready[exp_tgt]);
        exp_accept = m_avalid && exp_ready;
    endtask

    task automatic model_commit();
        if (exp_rvalid) void'(mq.pop_front());
        if (exp_accept && exp_read) mq.push_back(exp_tgt);
        err_due = exp_accept && exp_read && (exp_tgt == NS);
        if (err_clr) exp_err = 1'b0;
        else if (exp_accept && exp_tgt == NS) exp_err = 1'b1;
    endtask

    task automatic set_idle();
        m_avalid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rvalid = '0; s_rdata = '0; err_clr = 1'b0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [3:0] strb);
        m_avalid = 1'b1; m_addr = a; m_wstrb = strb; m_wdata = 32'h0BAD_F00D;
    endtask

    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!arst && cke) model_commit();
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", m_rvalid); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", m_rdata); end
        checks++; if (s_avalid !== 3'b000) begin errors++; $display("FAIL rst_savalid got %b want 000", s_avalid); end
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_idle(); s_ready = 3'b010;
        set_req(32'h4000_0000, 4'h0); settle();
        checks++; if (s_avalid !== 3'b010) begin errors++; $display("FAIL b2b_sav0 got %b want 010", s_avalid); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", m_ready); end
        tick();
        set_req(32'h4000_0004, 4'h0); settle();
        checks++; if (s_avalid !== 3'b010) begin errors++; $display("FAIL b2b_sav1 got %b want 010", s_avalid); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", m_ready); end
        tick();
        m_avalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 3'b010; s_rdata = {32'h0, 32'h1111_0000 + i, 32'h0}; settle();
            checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d got %b want 1", i, m_rvalid); end
            checks++; if (m_rdata !== 32'h1111_0000 + i) begin errors++; $display("FAIL b2b_rdata%0d got %h want %h", i, m_rdata, 32'h1111_0000 + i); end
            tick();
        end
        settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", m_rvalid); end
        tick(); set_idle();
    endtask

    task automatic test_full_stall();
        set_idle(); s_ready = 3'b001;
        for (int i = 0; i < MAXO; i++) begin
            set_req(32'h0, 4'h0); settle();
            checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL full_acc%0d got %b want 1", i, m_ready); end
            tick();
        end
        settle();
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL full_stall_ready got %b want 0", m_ready); end
        checks++; if (s_avalid !== 3'b000) begin errors++; $display("FAIL full_stall_sav got %b want 000", s_avalid); end
        s_rvalid = 3'b001; s_rdata = {64'h0, 32'h0000_AAAA}; settle();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL full_release_ready got %b want 1", m_ready); end
        checks++; if (s_avalid !== 3'b001) begin errors++; $display("FAIL full_release_sav got %b want 001", s_avalid); end
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL full_release_rvalid got %b want 1", m_rvalid); end
        tick();
        m_avalid = 1'b0;
        for (int i = 0; i < MAXO; i++) begin
            settle();
            checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL full_drain%0d got %b want 1", i, m_rvalid); end
            tick();
        end
        settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", m_rvalid); end
        tick(); set_idle();
    endtask

    task automatic test_switch_stall();
        set_idle(); s_ready = 3'b011;
        set_req(32'h0, 4'h0); settle(); tick();
        set_req(32'h4000_0000, 4'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL sw_stall%0d got %b want 0", i, m_ready); end
            checks++; if (s_avalid !== 3'b000) begin errors++; $display("FAIL sw_sav%0d got %b want 000", i, s_avalid); end
            tick();
        end
        s_rvalid = 3'b001; settle();
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL sw_rsp0 got %b want 1", m_rvalid); end
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL sw_same_cycle got %b want 0", m_ready); end
        tick();
        s_rvalid = 3'b000; settle();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL sw_accept got %b want 1", m_ready); end
        checks++; if (s_avalid !== 3'b010) begin errors++; $display("FAIL sw_accept_sav got %b want 010", s_avalid); end
        tick();
        m_avalid = 1'b0; s_rvalid = 3'b011; s_rdata = {32'h0, 32'h0000_ABCD, 32'h0000_5555}; settle();
        checks++; if (m_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL sw_rdata got %h want 0000abcd", m_rdata); end
        tick(); set_idle();
    endtask

    task automatic test_unmapped();
        set_idle();
        set_req(32'hC000_0000, 4'h0); settle();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL um_ready got %b want 1", m_ready); end
        checks++; if (s_avalid !== 3'b000) begin errors++; $display("FAIL um_sav got %b want 000", s_avalid); end
        tick();
        m_avalid = 1'b0; settle();
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL um_rvalid got %b want 1", m_rvalid); end
        checks++; if (m_rdata !== ERRD) begin errors++; $display("FAIL um_rdata got %h want %h", m_rdata, ERRD); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL um_err got %b want 1", err); end
        tick(); settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL um_once got %b want 0", m_rvalid); end
        err_clr = 1'b1; set_req(32'hC000_0000, 4'hF); tick();
        set_idle(); settle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL um_clr_prio got %b want 1'b0", err); end
        set_req(32'hC000_0010, 4'h3); tick();
        set_idle(); settle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL um_wr_err got %b want 1", err); end
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL um_wr_norsp got %b want 0", m_rvalid); end
        // Clock enable low freezes the flag even with a clear request
        cke = 1'b0; err_clr = 1'b1; tick(); settle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL cke_hold got %b want 1", err); end
        cke = 1'b1; tick(); set_idle(); settle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cke_clr got %b want 0", err); end
    endtask

    task automatic test_spurious_write();
        set_idle(); s_rvalid = 3'b100; s_rdata = {32'h1234_5678, 64'h0}; settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL spur_rvalid got %b want 0", m_rvalid); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL spur_rdata got %h want 0", m_rdata); end
        s_rvalid = 3'b000; s_ready = 3'b100; set_req(32'h8000_0000, 4'hF); settle();
        checks++; if (s_avalid !== 3'b100) begin errors++; $display("FAIL wr_sav got %b want 100", s_avalid); end
        tick();
        set_idle(); s_rvalid = 3'b100; settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL wr_norsp got %b want 0", m_rvalid); end
        tick(); set_idle();
    endtask

    task automatic test_async_reset();
        set_idle(); s_ready = 3'b001;
        for (int i = 0; i < MAXO; i++) begin set_req(32'h0, 4'h0); settle(); tick(); end
        set_idle(); s_rvalid = 3'b001; settle();
        checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", m_rvalid); end
        arst = 1'b1; model_reset(); #1;
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL ar_immediate got %b want 0", m_rvalid); end
        tick();
        arst = 1'b0; settle();
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL ar_late_rsp got %b want 0", m_rvalid); end
        tick();
        set_idle(); s_ready = 3'b010; set_req(32'h4000_0000, 4'h0); settle();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL ar_first_acc got %b want 1", m_ready); end
        tick();
        set_idle(); s_rvalid = 3'b010; s_rdata = {32'h0, 32'h7777_7777, 32'h0}; settle();
        checks++; if (m_rdata !== 32'h7777_7777) begin errors++; $display("FAIL ar_first_rsp got %h want 77777777", m_rdata); end
        tick(); set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cke      = ($urandom_range(0, 7) != 0);
            m_avalid = ($urandom_range(0, 3) != 0);
            m_addr   = {2'($urandom_range(0, 3)), 30'($urandom)};
            m_wdata  = $urandom;
            m_wstrb  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            s_ready  = 3'($urandom);
            s_rvalid = 3'($urandom);
            s_rdata  = {$urandom, $urandom, $urandom};
            err_clr  = ($urandom_range(0, 15) == 0);
            settle();
            checks++; if (m_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, m_ready, exp_ready); end
            checks++; if (s_avalid !== exp_sav) begin errors++; $display("FAIL rnd_sav[%0d] got %b want %b", i, s_avalid, exp_sav); end
            checks++; if (m_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d] got %b want %b", i, m_rvalid, exp_rvalid); end
            checks++; if (m_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, m_rdata, exp_rdata); end
            checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", i, err, exp_err); end
            checks++; if ({s_addr, s_wdata, s_wstrb} !== {m_addr, m_wdata, m_wstrb}) begin errors++; $display("FAIL rnd_pass[%0d] got %h want %h", i, {s_addr, s_wdata, s_wstrb}, {m_addr, m_wdata, m_wstrb}); end
            tick();
        end
        cke = 1'b1; set_idle();
    endtask

    initial begin
        arst = 1'b1; cke = 1'b1;
        set_idle();
        model_reset();
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_switch_stall();
        test_unmapped();
        test_spurious_write();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
